// File: rtl/fir_pkg.sv
// Shared constants and types for the FIR input-stream source.
package fir_pkg;

    localparam int unsigned DATA_WIDTH = 13;
    localparam int unsigned TAPS       = 8;
    localparam int unsigned FIFO_DEPTH = 16;
    localparam int unsigned GAP_W      = 4;
    localparam int unsigned LEN_W      = 8;

    typedef logic signed [DATA_WIDTH-1:0] sample_t;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_DATA,
        TX_GAP,
        TX_FLUSH
    } tx_state_t;

endpackage

// File: rtl/fir_sample_fifo.sv
// Synchronous sample FIFO: registered full/empty/level, no write-to-read bypass.
module fir_sample_fifo #(
    parameter int unsigned DATA_WIDTH = 13,
    parameter int unsigned DEPTH      = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    push_i,
    input  logic [DATA_WIDTH-1:0]   wr_data_i,
    input  logic                    pop_i,
    output logic [DATA_WIDTH-1:0]   rd_data_c_o,
    output logic                    full_o,
    output logic                    empty_o,
    output logic [$clog2(DEPTH):0]  level_o
);
    import fir_pkg::*;

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]         wr_ptr_q;
    logic [AW-1:0]         rd_ptr_q;
    logic [LW-1:0]         count_q;
    logic [LW-1:0]         count_d;
    logic                  full_q;
    logic                  empty_q;
    logic                  push_ok;
    logic                  pop_ok;

    // A push while full is dropped even when a pop frees a slot this cycle.
    always_comb begin
        push_ok = push_i && !full_q;
        pop_ok  = pop_i && !empty_q;
        count_d = count_q + LW'(push_ok) - LW'(pop_ok);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
            full_q  <= (count_d == LW'(DEPTH));
            empty_q <= (count_d == '0);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wr_ptr_q] <= wr_data_i;
    end

    assign rd_data_c_o = mem_q[rd_ptr_q];
    assign full_o      = full_q;
    assign empty_o     = empty_q;
    assign level_o     = count_q;

endmodule

// File: rtl/fir_sample_tx.sv
// Burst source for the FIR input port: drains the sample FIFO onto VIN/DIN with a
// programmable gap and an optional TAPS-1 zero-sample flush tail.
module fir_sample_tx #(
    parameter int unsigned DATA_WIDTH = fir_pkg::DATA_WIDTH,
    parameter int unsigned TAPS       = fir_pkg::TAPS,
    parameter int unsigned FIFO_DEPTH = fir_pkg::FIFO_DEPTH,
    parameter int unsigned GAP_W      = fir_pkg::GAP_W
) (
    input  logic                           CLK,
    input  logic                           RST_n,
    input  logic                           WR_EN,
    input  logic signed [DATA_WIDTH-1:0]   WR_DATA,
    output logic                           FULL,
    output logic [$clog2(FIFO_DEPTH):0]    LEVEL,
    input  logic                           START,
    input  logic [fir_pkg::LEN_W-1:0]      LEN,
    input  logic [GAP_W-1:0]               GAP,
    input  logic                           FLUSH,
    output logic                           BUSY,
    output logic                           DONE,
    output logic                           UNDERRUN,
    output logic                           VIN,
    output logic signed [DATA_WIDTH-1:0]   DIN
);
    import fir_pkg::*;

    localparam int unsigned FC_W             = $clog2(TAPS);
    localparam logic [FC_W-1:0] FC_LAST      = FC_W'(TAPS - 2);

    tx_state_t             state_q, state_d, nxt_after;
    logic [LEN_W-1:0]      len_q, len_d, data_cnt_q, data_cnt_d;
    logic [GAP_W-1:0]      gap_q, gap_d, gap_cnt_q, gap_cnt_d;
    logic [FC_W-1:0]       flush_cnt_q, flush_cnt_d;
    logic                  flush_q, flush_d, to_flush_q, to_flush_d;
    logic                  vin_q, vin_d, busy_q, busy_d, done_q, done_d;
    logic                  fin_q, fin_d, underrun_q, underrun_d;
    logic [DATA_WIDTH-1:0] din_q, din_d;

    logic                  start_ok, data_due, pop, fifo_empty;
    logic                  last_data, last_flush, flush_pulse, gap_end;
    logic                  final_pulse, next_flush, flush_eff;
    logic [LEN_W-1:0]      len_eff, data_idx;
    logic [GAP_W-1:0]      gap_eff;
    logic [DATA_WIDTH-1:0] fifo_rd_data;

    fir_sample_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .clk_i       (CLK),
        .rst_ni      (RST_n),
        .push_i      (WR_EN),
        .wr_data_i   (WR_DATA),
        .pop_i       (pop),
        .rd_data_c_o (fifo_rd_data),
        .full_o      (FULL),
        .empty_o     (fifo_empty),
        .level_o     (LEVEL)
    );

    // The accepting IDLE cycle already issues the first sample, so burst
    // parameters come straight from the inputs in that cycle.
    always_comb begin
        start_ok    = START && (LEN != '0) && (state_q == TX_IDLE) && !busy_q;
        len_eff     = start_ok ? LEN   : len_q;
        gap_eff     = start_ok ? GAP   : gap_q;
        flush_eff   = start_ok ? FLUSH : flush_q;
        data_idx    = start_ok ? '0    : data_cnt_q;
        data_due    = start_ok || (state_q == TX_DATA);
        pop         = data_due && !fifo_empty;
        last_data   = (data_idx == LEN_W'(len_eff - LEN_W'(1)));
        flush_pulse = (state_q == TX_FLUSH);
        last_flush  = (flush_cnt_q == FC_LAST);
        gap_end     = (state_q == TX_GAP) && (gap_cnt_q == GAP_W'(gap_q - GAP_W'(1)));
        final_pulse = (pop && last_data && !flush_eff) || (flush_pulse && last_flush);
        next_flush  = flush_pulse || last_data;
        if (final_pulse)        nxt_after = TX_IDLE;
        else if (gap_eff != '0) nxt_after = TX_GAP;
        else if (next_flush)    nxt_after = TX_FLUSH;
        else                    nxt_after = TX_DATA;
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) state_q <= TX_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            TX_IDLE:  if (start_ok) state_d = pop ? nxt_after : TX_DATA;
            TX_DATA:  if (pop) state_d = nxt_after;
            TX_GAP:   if (gap_end) state_d = to_flush_q ? TX_FLUSH : TX_DATA;
            TX_FLUSH: state_d = nxt_after;
            default:  state_d = TX_IDLE;
        endcase
    end

    always_comb begin
        len_d       = len_q;
        gap_d       = gap_q;
        flush_d     = flush_q;
        data_cnt_d  = data_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        flush_cnt_d = flush_cnt_q;
        to_flush_d  = to_flush_q;
        underrun_d  = underrun_q;
        busy_d      = busy_q;
        din_d       = din_q;
        vin_d       = 1'b0;
        fin_d       = 1'b0;
        done_d      = fin_q;

        if (start_ok) begin
            len_d       = LEN;
            gap_d       = GAP;
            flush_d     = FLUSH;
            data_cnt_d  = '0;
            flush_cnt_d = '0;
            underrun_d  = 1'b0;
            busy_d      = 1'b1;
        end
        if (done_q) busy_d = 1'b0;

        if (data_due && fifo_empty) underrun_d = 1'b1;

        if (pop) begin
            vin_d      = 1'b1;
            din_d      = fifo_rd_data;
            data_cnt_d = data_idx + LEN_W'(1);
        end
        if (flush_pulse) begin
            vin_d       = 1'b1;
            din_d       = '0;
            flush_cnt_d = flush_cnt_q + FC_W'(1);
        end
        if ((pop || flush_pulse) && !final_pulse) to_flush_d = next_flush;

        if (state_q == TX_GAP) gap_cnt_d = gap_end ? '0 : gap_cnt_q + GAP_W'(1);

        if (final_pulse) begin
            fin_d       = 1'b1;
            data_cnt_d  = '0;
            flush_cnt_d = '0;
        end
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            len_q       <= '0;
            gap_q       <= '0;
            flush_q     <= 1'b0;
            data_cnt_q  <= '0;
            gap_cnt_q   <= '0;
            flush_cnt_q <= '0;
            to_flush_q  <= 1'b0;
            underrun_q  <= 1'b0;
            busy_q      <= 1'b0;
            din_q       <= '0;
            vin_q       <= 1'b0;
            fin_q       <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            len_q       <= len_d;
            gap_q       <= gap_d;
            flush_q     <= flush_d;
            data_cnt_q  <= data_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            to_flush_q  <= to_flush_d;
            underrun_q  <= underrun_d;
            busy_q      <= busy_d;
            din_q       <= din_d;
            vin_q       <= vin_d;
            fin_q       <= fin_d;
            done_q      <= done_d;
        end
    end

    assign BUSY     = busy_q;
    assign DONE     = done_q;
    assign UNDERRUN = underrun_q;
    assign VIN      = vin_q;
    assign DIN      = din_q;

endmodule

// File: tb/tb_fir_sample_tx.sv
// Directed bench for fir_sample_tx: bursts, gap/flush, underrun, FIFO limits, reset.
module tb_fir_sample_tx;
    import fir_pkg::*;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b1;
    logic                  wr_en = 1'b0;
    logic [DATA_WIDTH-1:0] wr_data = '0;
    logic                  full;
    logic [4:0]            level;
    logic                  start = 1'b0;
    logic [7:0]            len = '0;
    logic [3:0]            gap = '0;
    logic                  flush = 1'b0;
    logic                  busy, done, underrun, vin;
    logic [DATA_WIDTH-1:0] din;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    fir_sample_tx dut (
        .CLK      (clk),
        .RST_n    (rst_n),
        .WR_EN    (wr_en),
        .WR_DATA  (wr_data),
        .FULL     (full),
        .LEVEL    (level),
        .START    (start),
        .LEN      (len),
        .GAP      (gap),
        .FLUSH    (flush),
        .BUSY     (busy),
        .DONE     (done),
        .UNDERRUN (underrun),
        .VIN      (vin),
        .DIN      (din)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] s13(input int v);
        logic [12:0] t;
        t = 13'(v);
        return {19'b0, t};
    endfunction

    task automatic push(input int v);
        wr_en   = 1'b1;
        wr_data = 13'(v);
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic go(input int l, input int g, input bit f);
        start = 1'b1;
        len   = 8'(l);
        gap   = 4'(g);
        flush = f;
        tick();
        start = 1'b0;
    endtask

    initial begin
        int bexp [4];
        int busy_cnt;
        bexp = '{5, -3, 4095, -4096};

        // Reset
        #2 rst_n = 1'b0;
        tick();
        tick();
        check("rst_vin", 32'(vin), 0);
        check("rst_din", 32'(din), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_underrun", 32'(underrun), 0);
        check("rst_full", 32'(full), 0);
        check("rst_level", 32'(level), 0);
        rst_n = 1'b1;
        tick();

        // Basic back-to-back burst
        push(5); push(-3); push(4095); push(-4096);
        check("basic_level_pre", 32'(level), 4);
        go(4, 0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("basic_vin%0d", i), 32'(vin), 1);
            check($sformatf("basic_din%0d", i), 32'(din), s13(bexp[i]));
            check($sformatf("basic_busy%0d", i), 32'(busy), 1);
            tick();
        end
        check("basic_vin_end", 32'(vin), 0);
        check("basic_done", 32'(done), 1);
        check("basic_busy_done", 32'(busy), 1);
        check("basic_level", 32'(level), 0);
        check("basic_din_hold", 32'(din), s13(-4096));
        tick();
        check("basic_done_clr", 32'(done), 0);
        check("basic_busy_clr", 32'(busy), 0);

        // Gap 2 with flush tail; START in the DONE cycle must be ignored
        push(1); push(2); push(3);
        go(3, 2, 1'b1);
        busy_cnt = 0;
        for (int t = 1; t <= 30; t++) begin
            bit pulse;
            int p;
            pulse = (t <= 28) && (((t - 1) % 3) == 0);
            p     = (t - 1) / 3;
            if (busy) busy_cnt++;
            check($sformatf("gf_vin_t%0d", t), 32'(vin), 32'(pulse));
            if (pulse) check($sformatf("gf_din_t%0d", t), 32'(din), s13(p < 3 ? p + 1 : 0));
            check($sformatf("gf_busy_t%0d", t), 32'(busy), 32'(t <= 29));
            check($sformatf("gf_done_t%0d", t), 32'(done), 32'(t == 29));
            if (t == 29) begin
                start = 1'b1;
                len   = 8'd1;
            end
            tick();
            start = 1'b0;
        end
        check("gf_busy_span", 32'(busy_cnt), 29);
        check("gf_busy_after", 32'(busy), 0);
        check("gf_vin_after", 32'(vin), 0);
        check("gf_underrun", 32'(underrun), 0);

        // Underrun: entries become poppable at c+3 and c+6
        go(2, 0, 1'b0);
        for (int t = 1; t <= 9; t++) begin
            check($sformatf("ur_vin_t%0d", t), 32'(vin), 32'(t == 4 || t == 7));
            if (t == 4) check("ur_din7", 32'(din), 7);
            if (t == 7) check("ur_din8", 32'(din), 8);
            check($sformatf("ur_done_t%0d", t), 32'(done), 32'(t == 8));
            check($sformatf("ur_busy_t%0d", t), 32'(busy), 32'(t <= 8));
            check($sformatf("ur_flag_t%0d", t), 32'(underrun), 1);
            wr_en   = (t == 2) || (t == 5);
            wr_data = (t == 2) ? 13'd7 : 13'd8;
            tick();
            wr_en = 1'b0;
        end
        push(9);
        go(1, 0, 1'b0);
        check("ur_clear", 32'(underrun), 0);
        check("ur2_vin", 32'(vin), 1);
        check("ur2_din", 32'(din), 9);
        tick();
        check("ur2_done", 32'(done), 1);
        tick();

        // FIFO full, write dropped when full, and dropped even alongside a pop
        for (int i = 0; i < 17; i++) push(100 + i);
        check("ff_full", 32'(full), 1);
        check("ff_level16", 32'(level), 16);
        wr_en   = 1'b1;
        wr_data = 13'd999;
        go(16, 0, 1'b0);
        wr_en = 1'b0;
        check("ff_level15", 32'(level), 15);
        check("ff_full_clr", 32'(full), 0);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("ff_vin%0d", i), 32'(vin), 1);
            check($sformatf("ff_din%0d", i), 32'(din), s13(100 + i));
            tick();
        end
        check("ff_done", 32'(done), 1);
        check("ff_level_end", 32'(level), 0);
        tick();

        // Reset mid-burst after the third pulse
        for (int i = 1; i <= 8; i++) push(i * 10);
        go(8, 1, 1'b0);
        check("rm_p1", 32'(din), 10);
        tick();
        check("rm_gap1", 32'(vin), 0);
        tick();
        check("rm_p2", 32'(din), 20);
        tick();
        tick();
        check("rm_p3_vin", 32'(vin), 1);
        check("rm_p3_din", 32'(din), 30);
        #2 rst_n = 1'b0;
        #1;
        check("rm_vin", 32'(vin), 0);
        check("rm_din", 32'(din), 0);
        check("rm_busy", 32'(busy), 0);
        check("rm_level", 32'(level), 0);
        check("rm_full", 32'(full), 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("rm_nodone%0d", i), 32'(done), 0);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("rm_post_vin%0d", i), 32'(vin), 0);
            check($sformatf("rm_post_done%0d", i), 32'(done), 0);
            check($sformatf("rm_post_level%0d", i), 32'(level), 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
